// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM state encoding, SPI mode and a width helper.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_DONE
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Index width for a range of n entries, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_master_modes_if.sv
// Host-side request/response bundle of the SPI master.
interface spi_master_modes_if import spi_pkg::*; #(
    parameter int DATA_LENGTH = 8,
    parameter int NUM_CS      = 4
);
    localparam int CSW = idx_width(NUM_CS);

    logic                   start;
    logic [DATA_LENGTH-1:0] data_in;
    logic                   cpol;
    logic                   cpha;
    logic                   lsb_first;
    logic [CSW-1:0]         cs_sel;
    logic [DATA_LENGTH-1:0] data_out;
    logic                   busy;
    logic                   done;

    // Requester side: issues transfers, watches completion.
    modport master (
        output start, data_in, cpol, cpha, lsb_first, cs_sel,
        input  data_out, busy, done
    );

    // Controller side: the SPI master itself.
    modport slave (
        input  start, data_in, cpol, cpha, lsb_first, cs_sel,
        output data_out, busy, done
    );

endinterface

// File: rtl/spi_clk_gen.sv
// SCK generator: half-period counter, leading/trailing edge strobes and SCK level.
// tick marks the last cycle of each half period; lead/trail say which SCK edge
// the current clock edge produces while shifting.
module spi_clk_gen #(
    parameter int HP = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,       // timed phase active (setup, shift, hold)
    input  logic shift_en,  // SCK toggles only while shifting
    input  logic load,      // transfer accept: snap SCK to the new idle level
    input  logic load_lvl,
    input  logic idle_lvl,  // captured cpol of the running transfer
    output logic tick,
    output logic lead,
    output logic trail,
    output logic sck
);
    localparam int CW = (HP > 1) ? $clog2(HP) : 1;

    logic [CW-1:0] cnt;

    assign tick  = run && (cnt == CW'(HP - 1));
    assign lead  = tick && shift_en && (sck == idle_lvl);
    assign trail = tick && shift_en && (sck != idle_lvl);

    // Half-period counter; restarts at every tick so phases chain seamlessly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          cnt <= '0;
        else if (!run)       cnt <= '0;
        else if (tick)       cnt <= '0;
        else                 cnt <= cnt + 1'b1;
    end

    // SCK level: loaded with cpol on accept, toggled once per half period in shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                sck <= 1'b0;
        else if (load)             sck <= load_lvl;
        else if (tick && shift_en) sck <= ~sck;
    end

endmodule

// File: rtl/spi_master_modes.sv
// SPI master supporting all four CPOL/CPHA modes, either bit order and
// NUM_CS one-hot-low chip selects. FSM and shift registers live here; SCK
// timing comes from spi_clk_gen.
module spi_master_modes import spi_pkg::*; #(
    parameter int DATA_LENGTH = 8,
    parameter int CLK_DIV     = 4,
    parameter int NUM_CS      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_master_modes_if.slave bus,
    output logic              spi_sck,
    output logic              spi_mosi,
    output logic [NUM_CS-1:0] spi_cs_n,
    input  logic              spi_miso
);
    localparam int HP  = CLK_DIV / 2;
    localparam int CSW = idx_width(NUM_CS);
    localparam int EW  = idx_width(2 * DATA_LENGTH);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_LENGTH - 1);

    spi_state_t             state_q, state_d;
    spi_mode_t              mode_q;
    logic                   lsb_q;
    logic [CSW-1:0]         cs_q;
    logic [DATA_LENGTH-1:0] tx_q, rx_q, data_q;
    logic [EW-1:0]          edge_q;
    logic                   accept, active, tick, lead, trail, shift_tx, sample;

    assign accept = (state_q == ST_IDLE) && bus.start;
    assign active = state_q inside {ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD};

    spi_clk_gen #(.HP(HP)) u_clk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (active),
        .shift_en (state_q == ST_SHIFT),
        .load     (accept),
        .load_lvl (bus.cpol),
        .idle_lvl (mode_q.cpol),
        .tick     (tick),
        .lead     (lead),
        .trail    (trail),
        .sck      (spi_sck)
    );

    // First bit is already on MOSI from setup, so cpha=1 skips the first
    // leading edge and cpha=0 skips the final trailing edge.
    assign shift_tx = mode_q.cpha ? (lead && (edge_q != '0))
                                  : (trail && (edge_q != LAST_EDGE));
    assign sample   = mode_q.cpha ? trail : lead;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: each timed phase advances on the half-period tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (bus.start) state_d = ST_CS_SETUP;
            ST_CS_SETUP: if (tick) state_d = ST_SHIFT;
            ST_SHIFT:    if (tick && (edge_q == LAST_EDGE)) state_d = ST_CS_HOLD;
            ST_CS_HOLD:  if (tick) state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Capture configuration on accept; shift TX/RX on the mode's SCK edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= '0;
            lsb_q  <= 1'b0;
            cs_q   <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
            data_q <= '0;
            edge_q <= '0;
        end else if (accept) begin
            mode_q <= '{cpol: bus.cpol, cpha: bus.cpha};
            lsb_q  <= bus.lsb_first;
            cs_q   <= bus.cs_sel;
            tx_q   <= bus.data_in;
            edge_q <= '0;
        end else begin
            if (state_q == ST_SHIFT && tick)
                edge_q <= edge_q + 1'b1;
            if (shift_tx)
                tx_q <= lsb_q ? {1'b0, tx_q[DATA_LENGTH-1:1]}
                              : {tx_q[DATA_LENGTH-2:0], 1'b0};
            if (sample)
                rx_q <= lsb_q ? {spi_miso, rx_q[DATA_LENGTH-1:1]}
                              : {rx_q[DATA_LENGTH-2:0], spi_miso};
            if (state_q == ST_CS_HOLD && tick)
                data_q <= rx_q;
        end
    end

    // MOSI idles low; otherwise presents the current head of the TX register.
    always_comb begin
        spi_mosi = 1'b0;
        if (active) spi_mosi = lsb_q ? tx_q[0] : tx_q[DATA_LENGTH-1];
    end

    // Chip selects: selected line low during the timed phases; an
    // out-of-range index matches no line, so nothing is asserted.
    always_comb begin
        spi_cs_n = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (active && (cs_q == CSW'(i))) spi_cs_n[i] = 1'b0;
    end

    assign bus.data_out = data_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_spi_master_modes.sv
// Directed bench for spi_master_modes: a 4-CS instance with a mode-aware
// slave model, plus a 3-CS instance for the out-of-range select case.
module tb_spi_master_modes;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_master_modes_if #(.DATA_LENGTH(8), .NUM_CS(4)) bus ();
    spi_master_modes_if #(.DATA_LENGTH(8), .NUM_CS(3)) bus1 ();

    logic       spi_sck, spi_mosi, spi_miso;
    logic [3:0] spi_cs_n;
    logic       sck1, mosi1;
    logic [2:0] cs1_n;
    logic       miso1;

    spi_master_modes #(.DATA_LENGTH(8), .CLK_DIV(4), .NUM_CS(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .spi_miso(spi_miso)
    );

    spi_master_modes #(.DATA_LENGTH(8), .CLK_DIV(4), .NUM_CS(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .spi_sck(sck1), .spi_mosi(mosi1), .spi_cs_n(cs1_n), .spi_miso(miso1)
    );

    int checks = 0;
    int errors = 0;

    // Slave model state
    logic       s_en = 1'b0, s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0, s_loop = 1'b0;
    logic       s_first = 1'b0;
    logic [7:0] s_tx = 8'h00, s_rx = 8'h00;
    logic [3:0] s_idx = 4'd0;
    logic       s_bit;

    assign s_bit    = s_idx[3] ? 1'b0 : (s_lsb ? s_tx[s_idx[2:0]] : s_tx[3'd7 - s_idx[2:0]]);
    assign spi_miso = s_loop ? spi_mosi : s_bit;
    assign miso1    = 1'b0;

    // Slave reacts to every SCK edge: sample on its sample edge, advance otherwise.
    always @(spi_sck) begin
        if (s_en) begin
            if ((spi_sck != s_cpol) != s_cpha)
                s_rx <= s_lsb ? {spi_mosi, s_rx[7:1]} : {s_rx[6:0], spi_mosi};
            else if (s_first && s_cpha)
                s_first <= 1'b0;
            else
                s_idx <= s_idx + 4'd1;
        end
    end

    logic [3:0] cs_acc;
    logic [2:0] cs1_acc;
    logic       first_mosi, first_busy, first_sck, done_seen, prev_sck;
    int         lat, tog;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_xfer(input logic [7:0] d, input logic cp, input logic ch,
                              input logic lsb, input logic [1:0] cs);
        @(negedge clk);
        bus.data_in = d; bus.cpol = cp; bus.cpha = ch; bus.lsb_first = lsb; bus.cs_sel = cs;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic slave_arm(input logic cp, input logic ch, input logic lsb,
                             input logic [7:0] tx, input logic loop);
        s_cpol = cp; s_cpha = ch; s_lsb = lsb; s_tx = tx; s_loop = loop;
        s_idx = 4'd0; s_first = 1'b1; s_rx = 8'h00; s_en = 1'b1;
    endtask

    // Called just after the accept edge; cycle 1 is the first setup cycle.
    task automatic wait_done(output int l);
        l = 0;
        cs_acc = '0;
        for (int i = 1; i < 300; i++) begin
            @(negedge clk);
            if (i == 1) begin
                first_mosi = spi_mosi; first_busy = bus.busy; first_sck = spi_sck;
            end
            cs_acc |= ~spi_cs_n;
            if (bus.done) begin l = i; break; end
        end
        s_en = 1'b0;
    endtask

    task automatic idle_check(input string tag, input logic cp);
        @(negedge clk);
        check({tag, "_idle_sck"},  32'(spi_sck),  32'(cp));
        check({tag, "_idle_cs"},   32'(spi_cs_n), 32'hF);
        check({tag, "_idle_mosi"}, 32'(spi_mosi), 32'h0);
        check({tag, "_idle_busy"}, 32'(bus.busy), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 0; bus.data_in = 0; bus.cpol = 0; bus.cpha = 0; bus.lsb_first = 0; bus.cs_sel = 0;
        bus1.start = 0; bus1.data_in = 0; bus1.cpol = 0; bus1.cpha = 0; bus1.lsb_first = 0; bus1.cs_sel = 0;

        // Reset values
        #12;
        check("rst_cs",   32'(spi_cs_n),     32'hF);
        check("rst_sck",  32'(spi_sck),      32'h0);
        check("rst_mosi", 32'(spi_mosi),     32'h0);
        check("rst_busy", 32'(bus.busy),     32'h0);
        check("rst_done", 32'(bus.done),     32'h0);
        check("rst_dout", 32'(bus.data_out), 32'h0);
        check("rst_cs1",  32'(cs1_n),        32'h7);
        @(negedge clk);
        rst_n = 1'b1;

        // Mode 0, MSB first, loopback
        start_xfer(8'hAA, 1'b0, 1'b0, 1'b0, 2'd0);
        slave_arm(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        wait_done(lat);
        check("m0_latency", 32'(lat),          32'd37);
        check("m0_dout",    32'(bus.data_out), 32'hAA);
        check("m0_mosi",    32'(s_rx),         32'hAA);
        check("m0_cs",      32'(cs_acc),       32'h1);
        check("m0_busy",    32'(first_busy),   32'h1);
        check("m0_first",   32'(first_mosi),   32'h1);
        check("m0_setsck",  32'(first_sck),    32'h0);
        idle_check("m0", 1'b0);

        // Modes 1..3 against slave returning 3C
        for (int m = 1; m < 4; m++) begin
            logic [1:0] mv;
            mv = 2'(m);
            start_xfer(8'hC5, mv[1], mv[0], 1'b0, 2'd1);
            slave_arm(mv[1], mv[0], 1'b0, 8'h3C, 1'b0);
            wait_done(lat);
            check($sformatf("m%0d_latency", m), 32'(lat),          32'd37);
            check($sformatf("m%0d_dout", m),    32'(bus.data_out), 32'h3C);
            check($sformatf("m%0d_slave", m),   32'(s_rx),         32'hC5);
            check($sformatf("m%0d_setsck", m),  32'(first_sck),    32'(mv[1]));
            check($sformatf("m%0d_cs", m),      32'(cs_acc),       32'h2);
            idle_check($sformatf("m%0d", m), mv[1]);
        end

        // LSB first
        start_xfer(8'h01, 1'b0, 1'b0, 1'b1, 2'd0);
        slave_arm(1'b0, 1'b0, 1'b1, 8'h80, 1'b0);
        wait_done(lat);
        check("lsb_first_bit", 32'(first_mosi),   32'h1);
        check("lsb_dout",      32'(bus.data_out), 32'h80);
        check("lsb_slave",     32'(s_rx),         32'h01);

        // Chip select 2 then 3
        start_xfer(8'h96, 1'b0, 1'b0, 1'b0, 2'd2);
        slave_arm(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        wait_done(lat);
        check("cs2_lines", 32'(cs_acc),       32'h4);
        check("cs2_dout",  32'(bus.data_out), 32'h96);
        start_xfer(8'h69, 1'b0, 1'b0, 1'b0, 2'd3);
        slave_arm(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        wait_done(lat);
        check("cs3_lines", 32'(cs_acc),       32'h8);
        check("cs3_dout",  32'(bus.data_out), 32'h69);

        // Start held high with data changed mid-transfer
        @(negedge clk);
        bus.data_in = 8'hAA; bus.cpol = 0; bus.cpha = 0; bus.lsb_first = 0; bus.cs_sel = 0;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.data_in = 8'h55;
        slave_arm(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        wait_done(lat);
        check("hold_latency", 32'(lat),          32'd37);
        check("hold_dout1",   32'(bus.data_out), 32'hAA);
        check("hold_mosi1",   32'(s_rx),         32'hAA);
        @(negedge clk);
        check("hold_gap_busy", 32'(bus.busy), 32'h0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        slave_arm(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        wait_done(lat);
        check("hold_busy2",    32'(first_busy),   32'h1);
        check("hold_latency2", 32'(lat),          32'd37);
        check("hold_dout2",    32'(bus.data_out), 32'h55);

        // Reset at the fifth SCK edge of shift
        start_xfer(8'h33, 1'b0, 1'b0, 1'b0, 2'd1);
        slave_arm(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        tog = 0;
        prev_sck = spi_sck;
        for (int i = 0; i < 100 && tog < 5; i++) begin
            @(negedge clk);
            if (spi_sck !== prev_sck) begin tog++; prev_sck = spi_sck; end
        end
        check("rstmid_edges", 32'(tog), 32'd5);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_cs",   32'(spi_cs_n),     32'hF);
        check("rstmid_sck",  32'(spi_sck),      32'h0);
        check("rstmid_mosi", 32'(spi_mosi),     32'h0);
        check("rstmid_busy", 32'(bus.busy),     32'h0);
        check("rstmid_dout", 32'(bus.data_out), 32'h0);
        done_seen = 1'b0;
        repeat (3) begin @(negedge clk); done_seen |= bus.done; end
        rst_n = 1'b1;
        repeat (40) begin @(negedge clk); done_seen |= bus.done; end
        s_en = 1'b0;
        check("rstmid_nodone", 32'(done_seen), 32'h0);
        start_xfer(8'h0F, 1'b0, 1'b0, 1'b0, 2'd0);
        slave_arm(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        wait_done(lat);
        check("after_rst_latency", 32'(lat),          32'd37);
        check("after_rst_dout",    32'(bus.data_out), 32'h0F);

        // NUM_CS=3 with out-of-range select: no line asserted
        @(negedge clk);
        bus1.data_in = 8'h5A; bus1.cs_sel = 2'd3; bus1.start = 1'b1;
        @(posedge clk);
        #1 bus1.start = 1'b0;
        lat = 0;
        cs1_acc = '0;
        for (int i = 1; i < 300; i++) begin
            @(negedge clk);
            cs1_acc |= ~cs1_n;
            if (bus1.done) begin lat = i; break; end
        end
        check("oor_latency", 32'(lat),           32'd37);
        check("oor_cs",      32'(cs1_acc),       32'h0);
        check("oor_dout",    32'(bus1.data_out), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master_modes.md
SPI_MASTER_MODES -- requirements
Module: spi_master_modes

Interface
REQ-001 Parameter DATA_LENGTH, default 8, word length in bits (>=2).
REQ-002 Parameter CLK_DIV, default 4, system-clock cycles per SCK period (even, >=2); half-period HP = CLK_DIV/2.
REQ-003 Parameter NUM_CS, default 4, number of chip-select lines (>=1).
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  transfer request; accepted only when busy=0.
REQ-007 data_in  input  DATA_LENGTH  word to transmit; captured on accept.
REQ-008 cpol  input  1  SCK idle level; captured on accept.
REQ-009 cpha  input  1  0: sample on leading edge; 1: sample on trailing edge; captured on accept.
REQ-010 lsb_first  input  1  bit order; captured on accept.
REQ-011 cs_sel  input  $clog2(NUM_CS) (min 1)  target slave index; captured on accept.
REQ-012 data_out  output  DATA_LENGTH  received word, valid from the done pulse until the next accept.
REQ-013 busy  output  1  high from the cycle after accept until the done cycle inclusive.
REQ-014 done  output  1  single-cycle completion pulse.
REQ-015 spi_sck, spi_mosi  output  1 each; spi_cs_n  output  NUM_CS  active-low, one-hot-low when active.
REQ-016 spi_miso  input  1  serial data from slave.

Function
REQ-017 FSM states IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> DONE -> IDLE.
REQ-018 IDLE: start=1 captures data_in/cpol/cpha/lsb_first/cs_sel; next state CS_SETUP.
REQ-019 CS_SETUP lasts HP cycles; spi_cs_n[cs_sel]=0, spi_sck=cpol, first bit driven on spi_mosi.
REQ-020 SHIFT generates exactly 2*DATA_LENGTH SCK edges, one every HP cycles, starting at the level cpol.
REQ-021 cpha=0: MISO sampled on each leading edge; next MOSI bit driven on each trailing edge (none after the last).
REQ-022 cpha=1: MOSI bit driven on each leading edge; MISO sampled on each trailing edge.
REQ-023 lsb_first=0 sends data_in[DATA_LENGTH-1] first and places the first received bit in data_out[DATA_LENGTH-1]; lsb_first=1 mirrors both.
REQ-024 CS_HOLD lasts HP cycles with SCK at cpol and CS still asserted; then all spi_cs_n bits high.
REQ-025 DONE lasts 1 cycle: done=1, data_out updated; IDLE follows, and a new accept is possible on the next cycle.
REQ-026 Total accept-to-done latency = 1 + HP*(2*DATA_LENGTH+2) cycles.
REQ-027 start while busy=1 is ignored; captured configuration is never altered mid-transfer.
REQ-028 cs_sel >= NUM_CS: the transfer runs with every spi_cs_n bit held high (no slave selected).
REQ-029 In IDLE spi_sck equals the cpol captured by the last accept; spi_mosi=0.

Reset
REQ-030 rst_n=0 at any time, including mid-transfer, forces IDLE within the same instant (asynchronous).
REQ-031 Reset values: spi_cs_n all ones, spi_sck=0, spi_mosi=0, busy=0, done=0, data_out=0, captured cpol=0.
REQ-032 No done pulse is generated for a transfer aborted by reset.

Structure
REQ-033 Shared package spi_pkg holds the FSM state enum and an SPI-mode typedef {cpol, cpha}.
REQ-034 One sub-module spi_clk_gen (HP counter, edge strobes lead/trail, SCK level); the FSM and shift register stay in the top.

Verification
REQ-035 Mode 0, MSB-first, cs_sel=0, data_in=8'hAA, MISO loopback -> MOSI 1,0,1,0,1,0,1,0; data_out=8'hAA; done at cycle 37 after accept (CLK_DIV=4).
REQ-036 Modes 1, 2, 3 with slave model returning 8'h3C, data_in=8'hC5 -> data_out=8'h3C, slave captures 8'hC5, SCK idle=cpol in each mode.
REQ-037 lsb_first=1, data_in=8'h01, slave returns 8'h80 -> first MOSI bit 1; data_out=8'h80.
REQ-038 cs_sel=2 then cs_sel=3 (NUM_CS=4) -> only spi_cs_n[2], then only [3], go low; cs_sel out of range (non-power-of-2 NUM_CS=3, cs_sel=3) -> no CS asserted.
REQ-039 start held high during a transfer with changed data_in=8'h55 -> first transfer unaffected; second transfer starts the cycle after done.
REQ-040 rst_n pulsed low at edge 5 of SHIFT -> outputs at reset values immediately, no done; a following transfer of 8'h0F completes normally.
